// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_pkg
// Description : Shared definitions for the comparator sweep driver. It holds
//               the comparator result bit positions, the one-hot result codes
//               and the sweep FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

  // Bit positions inside the 4-bit result code {1'b0, gt, eq, lt}
  localparam int LT = 0;
  localparam int EQ = 1;
  localparam int GT = 2;

  // Only these three codes count as valid comparator results
  localparam logic [3:0] R_LT = 4'b0001;
  localparam logic [3:0] R_EQ = 4'b0010;
  localparam logic [3:0] R_GT = 4'b0100;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cmp_golden.sv
`default_nettype none
// ============================================================================
// Module      : cmp_golden
// Description : Combinational reference magnitude comparator (unsigned).
//               Ports:
//                 i_a, i_b : W-bit operands
//                 o_code   : {1'b0, a>b, a==b, a<b}
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_golden
  import cmp_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [3:0]   o_code
);

  always_comb begin
    o_code     = 4'b0000;
    o_code[LT] = (i_a <  i_b);
    o_code[EQ] = (i_a == i_b);
    o_code[GT] = (i_a >  i_b);
  end

endmodule
`default_nettype wire

// File: rtl/cmp_sweep_driver.sv
`default_nettype none
// ============================================================================
// Module      : cmp_sweep_driver
// Description : Drives every (a, b) operand pair onto a W-bit magnitude
//               comparator, samples its 4-bit result one cycle later, checks
//               it against a built-in golden model and tallies lt/eq/gt/error
//               counts.
//               Ports:
//                 clk, rst_n    : clock, asynchronous active-low reset
//                 start         : begin a sweep (honoured in IDLE/DONE only)
//                 pause         : freeze the sweep while high
//                 a_out, b_out  : operands to the comparator
//                 r_in          : comparator result {1'b0, gt, eq, lt}
//                 busy, done    : sweep in progress / sweep finished
//                 lt/eq/gt_cnt  : valid one-hot result tallies
//                 err_cnt       : results differing from the golden code
//                 err_flag      : sticky "any error seen"
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_sweep_driver
  import cmp_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = 2 * W + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          pause,
  output logic [W-1:0]  a_out,
  output logic [W-1:0]  b_out,
  input  logic [3:0]    r_in,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] lt_cnt,
  output logic [CW-1:0] eq_cnt,
  output logic [CW-1:0] gt_cnt,
  output logic [CW-1:0] err_cnt,
  output logic          err_flag
);

  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] PAIR_ONE = {{(2*W-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [CW-1:0]  lt_q, lt_d;
  logic [CW-1:0]  eq_q, eq_d;
  logic [CW-1:0]  gt_q, gt_d;
  logic [CW-1:0]  err_q, err_d;
  logic           err_flag_q, err_flag_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [3:0]     golden;
  logic [2*W-1:0] pair_nxt;
  logic           last_pair;

  cmp_golden #(.W(W)) u_golden (
    .i_a    (a_q),
    .i_b    (b_q),
    .o_code (golden)
  );

  // Treating {a, b} as one counter makes b the fast digit and carries into a
  // exactly when b wraps.
  assign pair_nxt  = {a_q, b_q} + PAIR_ONE;
  assign last_pair = &{a_q, b_q};

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    lt_d       = lt_q;
    eq_d       = eq_q;
    gt_d       = gt_q;
    err_d      = err_q;
    err_flag_d = err_flag_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d        = '0;
          b_d        = '0;
          lt_d       = '0;
          eq_d       = '0;
          gt_d       = '0;
          err_d      = '0;
          err_flag_d = 1'b0;
          state_d    = S_DRIVE;
        end
      end

      // Operands have been stable for this cycle; the comparator settles.
      S_DRIVE: begin
        if (!pause) begin
          state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        if (!pause) begin
          if (r_in == R_LT) lt_d = lt_q + CNT_ONE;
          if (r_in == R_EQ) eq_d = eq_q + CNT_ONE;
          if (r_in == R_GT) gt_d = gt_q + CNT_ONE;
          if (r_in != golden) begin
            err_d      = err_q + CNT_ONE;
            err_flag_d = 1'b1;
          end
          if (last_pair) begin
            // Operands stay on the final pair while DONE is shown.
            state_d = S_DONE;
          end else begin
            {a_d, b_d} = pair_nxt;
            state_d    = S_DRIVE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered versions of the next state.
    busy_d = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      lt_q       <= '0;
      eq_q       <= '0;
      gt_q       <= '0;
      err_q      <= '0;
      err_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      lt_q       <= lt_d;
      eq_q       <= eq_d;
      gt_q       <= gt_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign a_out    = a_q;
  assign b_out    = b_q;
  assign lt_cnt   = lt_q;
  assign eq_cnt   = eq_q;
  assign gt_cnt   = gt_q;
  assign err_cnt  = err_q;
  assign err_flag = err_flag_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cmp_sweep_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmp_sweep_driver
// Description : Directed self-checking bench for cmp_sweep_driver (W=4).
//               The comparator input is either an ideal cmp_golden instance
//               or a constant code, chosen by r_mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_sweep_driver;

  localparam int W  = 4;
  localparam int CW = 2 * W + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          pause;
  logic [W-1:0]  a_out;
  logic [W-1:0]  b_out;
  logic [3:0]    r_in;
  logic [3:0]    ideal_r;
  logic          busy;
  logic          done;
  logic [CW-1:0] lt_cnt;
  logic [CW-1:0] eq_cnt;
  logic [CW-1:0] gt_cnt;
  logic [CW-1:0] err_cnt;
  logic          err_flag;

  int r_mode;
  int checks;
  int errors;

  cmp_sweep_driver #(.W(W), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pause    (pause),
    .a_out    (a_out),
    .b_out    (b_out),
    .r_in     (r_in),
    .busy     (busy),
    .done     (done),
    .lt_cnt   (lt_cnt),
    .eq_cnt   (eq_cnt),
    .gt_cnt   (gt_cnt),
    .err_cnt  (err_cnt),
    .err_flag (err_flag)
  );

  cmp_golden #(.W(W)) u_ideal (
    .i_a    (a_out),
    .i_b    (b_out),
    .o_code (ideal_r)
  );

  assign r_in = (r_mode == 0) ? ideal_r :
                (r_mode == 1) ? 4'b0010 : 4'b0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise start so that the next rising edge is "edge 0" of the sweep.
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
  endtask

  // Count negedges after edge 0; done seen at negedge n means it rose after
  // edge n-1.  Optional pause window covers edges 100..109.
  task automatic wait_done(input bit keep_start, input bit do_pause, output int edges);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      if (!keep_start) start = 1'b0;
      if (do_pause && n == 100) pause = 1'b1;
      if (do_pause && n == 110) pause = 1'b0;
      if (done) seen = 1'b1;
    end
    edges = n - 1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout got done=%0b after %0d edges, want done=1", done, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({busy, done, err_flag} !== 3'b000) begin errors++; $display("FAIL reset_status got %b want 000", {busy, done, err_flag}); end
    checks++; if ({a_out, b_out} !== 8'h00) begin errors++; $display("FAIL reset_operands got %h want 00", {a_out, b_out}); end
    checks++; if ({lt_cnt, eq_cnt, gt_cnt, err_cnt} !== '0) begin errors++; $display("FAIL reset_counters got %0d/%0d/%0d/%0d want 0", lt_cnt, eq_cnt, gt_cnt, err_cnt); end
    rst_n = 1'b1;
    pause = 1'b1;  // ignored while idle
    repeat (3) @(negedge clk);
    pause = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL idle_hold got busy/done %b want 00", {busy, done}); end
  endtask

  task automatic test_ideal();
    int e;
    r_mode = 0;
    kick();
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ideal_busy got %0b want 1", busy); end
    checks++; if ({a_out, b_out} !== 8'h00) begin errors++; $display("FAIL ideal_first_pair got %h want 00", {a_out, b_out}); end
    wait_done(1'b0, 1'b0, e);
    e = e + 1;  // one negedge was consumed above
    checks++; if (e !== 512) begin errors++; $display("FAIL ideal_done_edge got %0d want 512", e); end
    checks++; if (lt_cnt !== 9'd120) begin errors++; $display("FAIL ideal_lt got %0d want 120", lt_cnt); end
    checks++; if (eq_cnt !== 9'd16) begin errors++; $display("FAIL ideal_eq got %0d want 16", eq_cnt); end
    checks++; if (gt_cnt !== 9'd120) begin errors++; $display("FAIL ideal_gt got %0d want 120", gt_cnt); end
    checks++; if (err_cnt !== 9'd0 || err_flag !== 1'b0) begin errors++; $display("FAIL ideal_err got %0d/%0b want 0/0", err_cnt, err_flag); end
    checks++; if ({a_out, b_out, busy} !== {8'hFF, 1'b0}) begin errors++; $display("FAIL ideal_hold got %h busy %0b want ff busy 0", {a_out, b_out}, busy); end
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ideal_done_sticky got %0b want 1", done); end
  endtask

  task automatic test_tied_eq();
    int e;
    r_mode = 1;
    kick();
    wait_done(1'b0, 1'b0, e);
    checks++; if (e !== 512) begin errors++; $display("FAIL tieq_done_edge got %0d want 512", e); end
    checks++; if (eq_cnt !== 9'd256) begin errors++; $display("FAIL tieq_eq got %0d want 256", eq_cnt); end
    checks++; if (lt_cnt !== 9'd0 || gt_cnt !== 9'd0) begin errors++; $display("FAIL tieq_ltgt got %0d/%0d want 0/0", lt_cnt, gt_cnt); end
    checks++; if (err_cnt !== 9'd240) begin errors++; $display("FAIL tieq_err got %0d want 240", err_cnt); end
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL tieq_flag got %0b want 1", err_flag); end
  endtask

  task automatic test_tied_zero();
    int e;
    r_mode = 2;
    kick();
    wait_done(1'b0, 1'b0, e);
    checks++; if ({lt_cnt, eq_cnt, gt_cnt} !== '0) begin errors++; $display("FAIL tizero_cats got %0d/%0d/%0d want 0", lt_cnt, eq_cnt, gt_cnt); end
    checks++; if (err_cnt !== 9'd256) begin errors++; $display("FAIL tizero_err got %0d want 256", err_cnt); end
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL tizero_flag got %0b want 1", err_flag); end
  endtask

  task automatic test_pause();
    int e;
    r_mode = 0;
    kick();
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL pause_preclear got %0b want 1", err_flag); end
    wait_done(1'b0, 1'b1, e);
    checks++; if (e !== 522) begin errors++; $display("FAIL pause_done_edge got %0d want 522", e); end
    checks++; if ({lt_cnt, eq_cnt, gt_cnt} !== {9'd120, 9'd16, 9'd120}) begin errors++; $display("FAIL pause_cats got %0d/%0d/%0d want 120/16/120", lt_cnt, eq_cnt, gt_cnt); end
    checks++; if (err_cnt !== 9'd0 || err_flag !== 1'b0) begin errors++; $display("FAIL pause_err got %0d/%0b want 0/0", err_cnt, err_flag); end
  endtask

  task automatic test_reset_mid();
    int e;
    r_mode = 0;
    kick();
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    // Pairs 0..98 sampled so far; next pair on the bus is (6,3).
    checks++; if ({lt_cnt, eq_cnt, gt_cnt} !== {9'd75, 9'd6, 9'd18}) begin errors++; $display("FAIL mid_cats got %0d/%0d/%0d want 75/6/18", lt_cnt, eq_cnt, gt_cnt); end
    checks++; if ({a_out, b_out, busy} !== {4'd6, 4'd3, 1'b1}) begin errors++; $display("FAIL mid_pair got %h busy %0b want 63 busy 1", {a_out, b_out}, busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, err_flag, a_out, b_out} !== '0) begin errors++; $display("FAIL async_reset_status got %b want 0", {busy, done, err_flag, a_out, b_out}); end
    checks++; if ({lt_cnt, eq_cnt, gt_cnt, err_cnt} !== '0) begin errors++; $display("FAIL async_reset_counters got %0d/%0d/%0d/%0d want 0", lt_cnt, eq_cnt, gt_cnt, err_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, a_out, b_out} !== '0) begin errors++; $display("FAIL post_reset_idle got %b want 0", {busy, done, a_out, b_out}); end
    kick();
    wait_done(1'b0, 1'b0, e);
    checks++; if (e !== 512) begin errors++; $display("FAIL rerun_done_edge got %0d want 512", e); end
    checks++; if ({lt_cnt, eq_cnt, gt_cnt, err_cnt} !== {9'd120, 9'd16, 9'd120, 9'd0}) begin errors++; $display("FAIL rerun_counts got %0d/%0d/%0d/%0d want 120/16/120/0", lt_cnt, eq_cnt, gt_cnt, err_cnt); end
  endtask

  task automatic test_start_held();
    int e;
    r_mode = 0;
    kick();
    wait_done(1'b1, 1'b0, e);
    checks++; if (e !== 512) begin errors++; $display("FAIL held_done_edge got %0d want 512", e); end
    checks++; if ({lt_cnt, eq_cnt, gt_cnt} !== {9'd120, 9'd16, 9'd120}) begin errors++; $display("FAIL held_cats got %0d/%0d/%0d want 120/16/120", lt_cnt, eq_cnt, gt_cnt); end
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL held_restart got done/busy %b want 01", {done, busy}); end
    checks++; if ({lt_cnt, eq_cnt, gt_cnt, a_out, b_out} !== '0) begin errors++; $display("FAIL held_clear got %0d/%0d/%0d pair %h want 0", lt_cnt, eq_cnt, gt_cnt, {a_out, b_out}); end
    start = 1'b0;
    wait_done(1'b0, 1'b0, e);
    checks++; if (e !== 511) begin errors++; $display("FAIL held_second_edge got %0d want 511", e); end
    checks++; if (eq_cnt !== 9'd16 || err_cnt !== 9'd0) begin errors++; $display("FAIL held_second_counts got %0d/%0d want 16/0", eq_cnt, err_cnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    r_mode = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    pause  = 1'b0;
    test_reset();
    test_ideal();
    test_tied_eq();
    test_tied_zero();
    test_pause();
    test_reset_mid();
    test_start_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmp_sweep_driver.md
Name: cmp_sweep_driver

Overview:
- Sequential driver-and-checker that sits on the operand side of the team's W-bit magnitude comparator.
- Sweeps every (a, b) operand pair onto the comparator inputs and samples the comparator's 4-bit result.
- Checks each result against an internal golden model and accumulates lt/eq/gt/error tallies.
- Intended as on-chip self-test and as a bench companion for the comparator.

Parameters:
- W, 4, operand width; also sets the sweep size of 2^(2W) pairs.
- CW, 2*W+1, width of every tally counter; holds 2^(2W) without overflow.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begins a sweep; sampled in IDLE or DONE only.
- pause  input  1  freezes the sweep while high (DRIVE/SAMPLE).
- a_out  output  W  operand a driven to the comparator.
- b_out  output  W  operand b driven to the comparator.
- r_in  input  4  comparator result, encoding {1'b0, gt, eq, lt}.
- busy  output  1  high in DRIVE or SAMPLE.
- done  output  1  high in DONE; stays high until the next start.
- lt_cnt, eq_cnt, gt_cnt  output  CW  count of pairs whose sampled r_in was the valid one-hot lt, eq or gt code.
- err_cnt  output  CW  count of pairs where r_in != golden.
- err_flag  output  1  sticky; set on the first error, cleared only by start or reset.

Behaviour:
- Reset: rst_n low forces state to IDLE asynchronously.
  - a_out, b_out, all counters, busy, done and err_flag go to 0 immediately, including mid-sweep.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE or DONE with start=1 at a clock edge:
  - clear the counters and err_flag;
  - set a_out = b_out = 0;
  - go to DRIVE.
- start in IDLE/DONE has priority over holding; start while busy is ignored.
- DRIVE: operands are stable; with pause=0 go to SAMPLE next edge. This is one settle cycle for the comparator.
- SAMPLE with pause=0, at the edge:
  - golden = {1'b0, a_out>b_out, a_out==b_out, a_out<b_out}, unsigned.
  - If r_in is exactly 4'b0001, 4'b0010 or 4'b0100, increment lt_cnt, eq_cnt or gt_cnt respectively.
  - Any other r_in value increments no category.
  - If r_in != golden, increment err_cnt and set err_flag.
  - Advance operands: b_out+1; when b_out wraps from 2^W-1 to 0, a_out+1.
  - If the pair was (2^W-1, 2^W-1), go to DONE with operands held; otherwise go to DRIVE.
- pause=1 in DRIVE or SAMPLE: state, operands and counters hold, and r_in is not sampled. pause is ignored in IDLE/DONE.
- Timing without pause:
  - each pair costs 2 cycles;
  - with start seen at edge 0, done rises after edge 2^(2W+1); for W=4 that is edge 512;
  - the first pair is driven from edge 0 onward.
- No counter can exceed 2^(2W), so no saturation logic is required.

Decomposition:
- Package cmp_pkg holds:
  - result bit indices LT=0, EQ=1, GT=2;
  - one-hot code constants R_LT, R_EQ, R_GT;
  - the FSM state encoding.
- Sub-module cmp_golden is purely combinational: (a, b) in, 4-bit expected code out, using the same encoding.
  - The bench reuses it as the ideal comparator model.

Test Plan:
- Ideal comparator (cmp_golden) on r_in, W=4, one start pulse -> done at edge 512; lt_cnt=120, eq_cnt=16, gt_cnt=120, err_cnt=0, err_flag=0.
- r_in tied to 4'b0010 -> eq_cnt=256, lt_cnt=gt_cnt=0, err_cnt=240, err_flag=1.
- r_in tied to 4'b0000 -> all category counts 0, err_cnt=256, err_flag=1.
- Ideal model, pause held high for 10 cycles at edge 100 -> done delayed to edge 522; counts identical to the first scenario.
- rst_n pulsed low at edge 200 -> all outputs 0 asynchronously, state IDLE; a new start gives the first scenario's results.
- start held high through an entire sweep -> no restart while busy; DONE lasts one cycle, then counters clear and a new sweep begins.
